add_chunked: RTL and testbench
==============================

// Module: add_chunked
// PURPOSE
//  Multi-cycle WIDTH-bit adder/subtractor that processes CHUNK bits per clock and carries between chunks in a register.
//  Successor to the flat combinational ripple adder. Used in the ALU datapath where a long adder chain must be split
//  across cycles. Operands and results move over valid/ready handshakes.
//  Results are sum, carry_out and signed overflow.
// PARAMETERS
//  WIDTH  32  operand/result width; must be a multiple of CHUNK
//  CHUNK  8   bits added per cycle; NCHUNK = WIDTH/CHUNK (default 4)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      asynchronous reset, active-low
//  in_valid   in   1      operand set present
//  in_ready   out  1      block can accept operands this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  carry_in   in   1      carry into bit 0
//  sub        in   1      1: compute a + ~b + carry_in (caller drives carry_in=1 for a-b)
//  out_valid  out  1      result registers valid
//  out_ready  in   1      consumer takes result this cycle
//  sum        out  WIDTH  result
//  carry_out  out  1      carry out of bit WIDTH-1
//  overflow   out  1      carry into MSB XOR carry out of MSB
//  busy       out  1      high in RUN state
// BEHAVIOUR
//  Reset: async on rst_n=0.
//   - state=IDLE; sum, carry_out, overflow, out_valid, busy all 0.
//   - Chunk counter and carry register cleared. Any in-flight operation is discarded.
//  FSM states: IDLE, RUN, DONE.
//   - IDLE: in_ready=1. If in_valid, latch a, (sub ? ~b : b) and carry_in; set k=0; go to RUN.
//   - RUN: each edge adds chunk k (bits k*CHUNK +: CHUNK) with the carry register, writes that slice of sum,
//     updates the carry register, then increments k. On the edge where k==NCHUNK-1, also register carry_out and
//     overflow, then go to DONE.
//   - DONE: out_valid=1. sum/carry_out/overflow hold stable until out_valid&&out_ready.
//     - If handshake completes and in_valid is high: accept the new operands on that same edge and go to RUN.
//     - If handshake completes and in_valid is low: go to IDLE.
//  in_ready = (state==IDLE) | (state==DONE & out_ready). Combinational from out_ready; no path from in_valid.
//  in_valid while RUN, or while DONE with out_ready=0, is ignored. Operands are not sampled.
//  Latency: operands accepted on edge E0 give out_valid=1 after edge E0+NCHUNK. Default is 4 cycles.
//  Throughput: one result per NCHUNK+1 cycles with continuous handshakes (DONE occupies one cycle).
//  sum slices not yet computed in RUN hold the previous result. They are not valid until out_valid.
//  Latched operands are immune to input changes after acceptance.
//  Arithmetic is modulo 2^WIDTH. Overflow is meaningful for two's-complement operands only.
//  CHUNK==WIDTH is legal: a single RUN cycle.
//  CHUNK not dividing WIDTH is a parameter error: $error at elaboration.
// STRUCTURE
//  Shared header add_defs.vh holds:
//   - FSM state localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
//   - A clog2 helper function for the chunk-counter width.
//  Sub-module add_chunk (combinational, CHUNK-wide ripple chain of full_adder) has ports a, b, carry_in, sum,
//  carry_out, carry_msb (carry into its top bit; feeds overflow).
//  One add_chunk instance is muxed by k. Top level holds the FSM, operand/carry registers and result registers.
// TESTING
//  1. a=0xFFFFFFFF b=1 cin=0 sub=0 -> sum=0 cout=1 ovf=0; out_valid rises exactly 4 cycles after accept.
//  2. a=0x7FFFFFFF b=1 cin=0 -> sum=0x80000000 cout=0 ovf=1.
//  3. a=5 b=7 sub=1 cin=1 -> sum=0xFFFFFFFE cout=0 ovf=0.
//     a=7 b=5 sub=1 cin=1 -> sum=2 cout=1.
//  4. Hold out_ready=0 for 3 cycles in DONE while in_valid=1 with new operands.
//     -> in_ready=0 and result stable throughout; new operands accepted on the edge where out_ready=1; busy next cycle.
//  5. Drop rst_n during RUN at k=2 -> all outputs 0 immediately (no clock).
//     After release: in_ready=1, out_valid stays 0 until a new operand set is accepted.
//  6. WIDTH=16 CHUNK=16, a=0x8000 b=0x8000 cin=0 -> sum=0 cout=1 ovf=1, latency 1 cycle.

Source files
------------

// File: rtl/add_chunked_pkg.sv
// Shared types and helpers for the chunked adder: FSM encoding, counter sizing
// and the single-bit full adder the chunk ripple chain is built from.
package add_chunked_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width of a counter that indexes n chunks; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Returns {carry, sum} of a single-bit full addition.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        return {((x & y) | (x & c) | (y & c)), (x ^ y ^ c)};
    endfunction

endpackage

// File: rtl/add_chunked_if.sv
// Operand/result handshake bundle of the chunked adder.
interface add_chunked_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             busy;

    modport master (
        output in_valid, a, b, carry_in, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow, busy
    );

    modport slave (
        input  in_valid, a, b, carry_in, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow, busy
    );
endinterface

// File: rtl/add_chunked_chunk.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its top bit
// so the caller can form signed overflow on the most significant chunk.
module add_chunked_chunk
    import add_chunked_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             carry_in,
    output logic [CHUNK-1:0] sum,
    output logic             carry_out,
    output logic             carry_msb
);
    logic [CHUNK:0] carry_s;

    // Ripple chain of full adders across the chunk.
    always_comb begin
        carry_s    = '0;
        sum        = '0;
        carry_s[0] = carry_in;
        for (int i = 0; i < CHUNK; i++) begin
            {carry_s[i+1], sum[i]} = full_add(a[i], b[i], carry_s[i]);
        end
    end

    assign carry_out = carry_s[CHUNK];
    assign carry_msb = carry_s[CHUNK-1];

endmodule

// File: rtl/add_chunked.sv
// Multi-cycle adder/subtractor: one CHUNK-wide slice per clock, carry held in a
// register between slices, operands and results on valid/ready handshakes.
module add_chunked
    import add_chunked_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    add_chunked_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = idx_width(NCHUNK);
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    if ((WIDTH % CHUNK) != 0) begin : g_param_check
        $error("add_chunked: CHUNK (%0d) must divide WIDTH (%0d)", CHUNK, WIDTH);
    end

    state_e                         state_r;
    state_e                         state_nxt_s;
    logic [NCHUNK-1:0][CHUNK-1:0]   a_r;
    logic [NCHUNK-1:0][CHUNK-1:0]   b_r;
    logic [NCHUNK-1:0][CHUNK-1:0]   sum_r;
    logic                           carry_r;
    logic                           carry_out_r;
    logic                           overflow_r;
    logic [KW-1:0]                  k_r;
    logic [CHUNK-1:0]               a_chunk_s;
    logic [CHUNK-1:0]               b_chunk_s;
    logic [CHUNK-1:0]               chunk_sum_s;
    logic                           chunk_cout_s;
    logic                           chunk_msb_s;
    logic                           in_ready_s;
    logic                           accept_s;
    logic                           last_s;

    assign in_ready_s = (state_r == ST_IDLE) | ((state_r == ST_DONE) & bus.out_ready);
    assign accept_s   = bus.in_valid & in_ready_s;
    assign last_s     = (k_r == K_LAST);

    // Select the operand slice addressed by the chunk counter (AND-OR mux).
    always_comb begin
        a_chunk_s = '0;
        b_chunk_s = '0;
        for (int j = 0; j < NCHUNK; j++) begin
            a_chunk_s = a_chunk_s | (a_r[j] & {CHUNK{k_r == KW'(j)}});
            b_chunk_s = b_chunk_s | (b_r[j] & {CHUNK{k_r == KW'(j)}});
        end
    end

    add_chunked_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a         (a_chunk_s),
        .b         (b_chunk_s),
        .carry_in  (carry_r),
        .sum       (chunk_sum_s),
        .carry_out (chunk_cout_s),
        .carry_msb (chunk_msb_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) state_nxt_s = ST_RUN;
                else              state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (last_s) state_nxt_s = ST_DONE;
                else        state_nxt_s = ST_RUN;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    if (bus.in_valid) state_nxt_s = ST_RUN;
                    else              state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Operand latch, per-chunk accumulation and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r         <= '0;
            b_r         <= '0;
            sum_r       <= '0;
            carry_r     <= 1'b0;
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
            k_r         <= '0;
        end else if (accept_s) begin
            // Subtraction is folded in here so the chunk adder only ever adds.
            a_r     <= bus.a;
            b_r     <= bus.sub ? ~bus.b : bus.b;
            carry_r <= bus.carry_in;
            k_r     <= '0;
        end else if (state_r == ST_RUN) begin
            for (int j = 0; j < NCHUNK; j++) begin
                if (k_r == KW'(j)) sum_r[j] <= chunk_sum_s;
            end
            carry_r <= chunk_cout_s;
            if (last_s) begin
                carry_out_r <= chunk_cout_s;
                overflow_r  <= chunk_msb_s ^ chunk_cout_s;
                k_r         <= '0;
            end else begin
                k_r <= k_r + 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = (state_r == ST_DONE);
    assign bus.busy      = (state_r == ST_RUN);
    assign bus.sum       = sum_r;
    assign bus.carry_out = carry_out_r;
    assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_add_chunked.sv
// Self-checking bench for add_chunked: a transaction-level model checked every
// cycle against the 32/8 instance, plus directed literal checks on both instances.
module tb_add_chunked;
    localparam int NCH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    add_chunked_if #(.WIDTH(32)) bus32 ();
    add_chunked_if #(.WIDTH(16)) bus16 ();

    add_chunked #(.WIDTH(32), .CHUNK(8)) u_dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus32)
    );

    add_chunked #(.WIDTH(16), .CHUNK(16)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Transaction-level model: pending result, cycles remaining, expected values.
    int          m_phase = 0;   // 0 empty, 1 computing, 2 result presented
    int          m_left  = 0;
    logic [31:0] m_sum   = 32'd0;
    logic        m_cout  = 1'b0;
    logic        m_ovf   = 1'b0;

    initial begin
        logic        rdy;
        logic [31:0] bb;
        logic [32:0] full;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_phase = 0;
            end else begin
                rdy = (m_phase == 0) || (m_phase == 2 && bus32.out_ready);
                if (m_phase == 1) begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end else if (m_phase == 2 && bus32.out_ready) begin
                    m_phase = 0;
                end
                if (bus32.in_valid && rdy) begin
                    bb      = bus32.sub ? ~bus32.b : bus32.b;
                    full    = {1'b0, bus32.a} + {1'b0, bb} + {32'd0, bus32.carry_in};
                    m_sum   = full[31:0];
                    m_cout  = full[32];
                    m_ovf   = (bus32.a[31] == bb[31]) && (full[31] != bus32.a[31]);
                    m_phase = 1;
                    m_left  = NCH;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of the 32-bit instance against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("m_in_ready", bus32.in_ready,
                      ((m_phase == 0) || (m_phase == 2 && bus32.out_ready)) ? 1 : 0);
                check("m_out_valid", bus32.out_valid, (m_phase == 2) ? 1 : 0);
                check("m_busy", bus32.busy, (m_phase == 1) ? 1 : 0);
                if (m_phase == 2) begin
                    check("m_sum", bus32.sum, m_sum);
                    check("m_cout", bus32.carry_out, m_cout);
                    check("m_ovf", bus32.overflow, m_ovf);
                end
            end
        end
    end

    // Wait for out_valid on the 32-bit instance, counting edges (bounded).
    task automatic wait_result32(output int lat);
        lat = 0;
        while (!bus32.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sb, input logic [31:0] es,
                          input logic ec, input logic eo);
        int lat;
        bus32.a        = a;
        bus32.b        = b;
        bus32.carry_in = cin;
        bus32.sub      = sb;
        bus32.in_valid = 1'b1;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        check({nm, "_busy"}, bus32.busy, 1);
        wait_result32(lat);
        check({nm, "_lat"}, lat, 4);
        check({nm, "_sum"}, bus32.sum, es);
        check({nm, "_cout"}, bus32.carry_out, ec);
        check({nm, "_ovf"}, bus32.overflow, eo);
        bus32.out_ready = 1'b1;
        @(posedge clk); #1;
        bus32.out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        bus32.in_valid = 1'b0; bus32.out_ready = 1'b0; bus32.a = 32'd0; bus32.b = 32'd0;
        bus32.carry_in = 1'b0; bus32.sub = 1'b0;
        bus16.in_valid = 1'b0; bus16.out_ready = 1'b0; bus16.a = 16'd0; bus16.b = 16'd0;
        bus16.carry_in = 1'b0; bus16.sub = 1'b0;

        #2;
        check("rst_sum", bus32.sum, 0);
        check("rst_out_valid", bus32.out_valid, 0);
        check("rst_busy", bus32.busy, 0);
        check("rst_cout", bus32.carry_out, 0);
        check("rst_ovf", bus32.overflow, 0);
        check("rst_in_ready", bus32.in_ready, 1);
        check("rst16_out_valid", bus16.out_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_op("posovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_op("sub5_7", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("ripple", 32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0);

        // Result held under back-pressure while new operands wait.
        bus32.a = 32'd7; bus32.b = 32'd5; bus32.carry_in = 1'b1; bus32.sub = 1'b1;
        bus32.in_valid = 1'b1;
        @(posedge clk); #1;
        bus32.a = 32'h1234_5678; bus32.b = 32'h0101_0101; bus32.carry_in = 1'b0; bus32.sub = 1'b0;
        wait_result32(lat);
        check("bp_lat", lat, 4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", bus32.in_ready, 0);
            check("bp_sum", bus32.sum, 32'h0000_0002);
            check("bp_cout", bus32.carry_out, 1);
            @(posedge clk); #1;
        end
        bus32.out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_hs", bus32.in_ready, 1);
        @(posedge clk); #1;
        bus32.out_ready = 1'b0;
        bus32.in_valid  = 1'b0;
        check("bp_busy_next", bus32.busy, 1);
        check("bp_out_valid_next", bus32.out_valid, 0);
        wait_result32(lat);
        check("bp2_lat", lat, 4);
        check("bp2_sum", bus32.sum, 32'h1335_5779);
        bus32.out_ready = 1'b1;
        @(posedge clk); #1;
        bus32.out_ready = 1'b0;

        // Asynchronous reset in the middle of a computation.
        bus32.a = 32'h1234_5678; bus32.b = 32'h1111_1111; bus32.carry_in = 1'b0; bus32.sub = 1'b0;
        bus32.in_valid = 1'b1;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_busy", bus32.busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst_sum", bus32.sum, 0);
        check("arst_busy", bus32.busy, 0);
        check("arst_out_valid", bus32.out_valid, 0);
        check("arst_cout", bus32.carry_out, 0);
        check("arst_ovf", bus32.overflow, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_in_ready", bus32.in_ready, 1);
            check("post_rst_out_valid", bus32.out_valid, 0);
        end
        @(posedge clk); #1;
        run_op("sub_min", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        run_op("sub7_5",  32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0);

        // Single-chunk instance: one RUN cycle.
        bus16.a = 16'h8000; bus16.b = 16'h8000; bus16.carry_in = 1'b0; bus16.sub = 1'b0;
        bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        lat = 0;
        while (!bus16.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w16_lat", lat, 1);
        check("w16_sum", bus16.sum, 16'h0000);
        check("w16_cout", bus16.carry_out, 1);
        check("w16_ovf", bus16.overflow, 1);
        bus16.out_ready = 1'b1;
        @(posedge clk); #1;
        bus16.out_ready = 1'b0;
        check("w16_idle", bus16.out_valid, 0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
